handle_game_end: RTL and testbench
==================================

// Module: handle_game_end
// PURPOSE
//   Generalised end-of-game detector and announcer for N-player interboard play.
//   Detects three end conditions and latches a sticky game_over with winner and reason:
//     - local win: my turn ends with an empty hand;
//     - remote win: a win message arrives from another board;
//     - draw: NUM_PLAYERS consecutive passes while the deck is empty.
//   Sits in GameControl beside the turn FSM and drives one interboard ctrl channel.
// PARAMETERS
//   PLAYER        0                 this board's player id (0..NUM_PLAYERS-1)
//   NUM_PLAYERS   2                 players in the game (2..4)
//   ID_W          3                 winner_id width; must hold NUM_PLAYERS (draw code)
//   MY_TURN_STATE `GAME_P1_WAIT_IN  cur_game_state value meaning "my turn, waiting input"
//   WIN_MSG       `STATE_I_WIN      msg type announcing a win; card[5:0] = winner id
//   PASS_MSG      `STATE_DRAW_PASS  msg type: remote player drew/passed with no play
//   PLAY_MSG      `STATE_DONE_NEXT  msg type: remote player ended turn after a play
//   TIMEOUT_CYC   1_000_000         max cycles to wait for inter_ready on a send
// PORTS
//   clk                      in   1   clock
//   rst                      in   1   synchronous active-high reset
//   interboard_rst           in   1   synchronous reset from link; same effect as rst
//   done_and_next            in   1   pulse: local turn ended after a play
//   draw_and_next            in   1   pulse: local turn ended by draw/pass
//   my_card_cnt              in   7   local hand size
//   deck_empty               in   1   draw pile exhausted
//   cur_game_state           in   4   game FSM state
//   inter_ready              in   1   interboard tx idle, accepts ctrl_en this cycle
//   interboard_en            in   1   pulse: valid rx message
//   interboard_msg_type      in   4   rx message type
//   interboard_card          in   6   rx card field (winner id for WIN_MSG)
//   game_over                out  1   sticky; high in FIN
//   winner_id                out  ID_W  winner; NUM_PLAYERS on draw
//   end_reason               out  2   0 none, 1 local win, 2 remote win, 3 draw
//   send_fail                out  1   sticky; win send timed out
//   ge_ctrl_en               out  1   one-cycle tx strobe
//   ge_ctrl_msg_type         out  4   constant WIN_MSG
//   ge_ctrl_card             out  6   PLAYER id
//   ge_ctrl_move_dir, ge_ctrl_sel_len, ge_ctrl_block_x, ge_ctrl_block_y  out  1/3/5/3  all 0
// BEHAVIOUR
//   Reset (rst | interboard_rst), any state, any cycle:
//     -> IDLE; pass_cnt = 0, timer = 0; game_over = 0, winner_id = 0,
//        end_reason = 0, send_fail = 0, ge_ctrl_en = 0.
//   my_turn = (cur_game_state == MY_TURN_STATE).
//   States:
//     IDLE -> SEND  on my_turn & done_and_next & my_card_cnt == 0 (local win).
//     IDLE -> FIN   on interboard_en & type == WIN_MSG; winner = card, reason 2.
//       If both events occur in the same cycle, lower id wins:
//         card < PLAYER -> remote win, else -> SEND.
//     IDLE -> FIN   reason 3, winner = NUM_PLAYERS, when pass_cnt would reach NUM_PLAYERS.
//       Any win event in the same cycle has priority over the draw.
//     SEND: ge_ctrl_en = inter_ready (combinational, exactly one cycle), then FIN with reason 1.
//       Latency: done_and_next at cycle t -> earliest ge_ctrl_en at t+1.
//       timer counts cycles with inter_ready low; timer == TIMEOUT_CYC-1 -> FIN, reason 1,
//       send_fail = 1, no strobe.
//       A remote WIN_MSG received in SEND with card < PLAYER -> FIN, reason 2, no strobe;
//       otherwise it is ignored.
//     FIN: sticky; all inputs ignored; only reset leaves it.
//   pass_cnt (3 bits, saturates at NUM_PLAYERS), updated in IDLE only:
//     +1 on (my_turn & draw_and_next & deck_empty) or (interboard_en & type == PASS_MSG & deck_empty).
//     Cleared on done_and_next, on interboard_en & type == PLAY_MSG, or when deck_empty is low.
//     Simultaneous increment and clear -> clear.
//   winner_id / end_reason are registered on entry to FIN and are stable while game_over = 1.
// TESTING
//   1. my_turn, done_and_next, cnt = 0, inter_ready = 1
//        -> ge_ctrl_en one cycle at t+1, card = PLAYER, game_over at t+2, reason 1.
//   2. Same as 1 with inter_ready low 5 cycles
//        -> exactly one strobe on the first ready cycle, reason 1, send_fail = 0.
//   3. inter_ready stuck low, TIMEOUT_CYC = 16
//        -> FIN after 16 SEND cycles, send_fail = 1, no strobe.
//   4. Rx WIN_MSG card = 1 (PLAYER = 0)
//        -> game_over, winner_id = 1, reason 2, no strobe.
//      Same cycle as a local win: PLAYER = 1, card = 0 -> reason 2, winner 0.
//   5. deck_empty, NUM_PLAYERS = 3, passes local/remote/remote -> reason 3, winner_id = 3.
//      A PLAY_MSG between passes -> no end.
//   6. Assert interboard_rst while in SEND and while in FIN
//        -> IDLE next cycle, all outputs 0.

Source files
------------

// File: rtl/handle_game_end.sv
// rtl/handle_game_end.sv - end-of-game detector and win announcer for N-player interboard play
//
// Purpose: watches local turn events and received interboard messages, then latches a
// sticky game_over together with the winner and the reason (local win, remote win, draw).
// A local win is announced to the other boards with a single WIN_MSG strobe.
//
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   interboard_rst             synchronous reset from the link, same effect as rst
//   done_and_next              pulse: local turn ended after a play
//   draw_and_next              pulse: local turn ended by draw/pass
//   my_card_cnt                local hand size
//   deck_empty                 draw pile exhausted
//   cur_game_state             game FSM state (compared with MY_TURN_STATE)
//   inter_ready                interboard tx idle, accepts ge_ctrl_en this cycle
//   interboard_en              pulse: valid rx message
//   interboard_msg_type        rx message type
//   interboard_card            rx card field (winner id for WIN_MSG)
//   game_over                  sticky end-of-game flag
//   winner_id                  winning player, NUM_PLAYERS on draw
//   end_reason                 0 none, 1 local win, 2 remote win, 3 draw
//   send_fail                  sticky: win announcement timed out
//   ge_ctrl_*                  interboard ctrl channel (one-cycle WIN_MSG strobe)

module handle_game_end #(
  parameter int unsigned PLAYER        = 0,
  parameter int unsigned NUM_PLAYERS   = 2,
  parameter int unsigned ID_W          = 3,
  parameter logic [3:0]  MY_TURN_STATE = 4'd3,
  parameter logic [3:0]  WIN_MSG       = 4'd9,
  parameter logic [3:0]  PASS_MSG      = 4'd10,
  parameter logic [3:0]  PLAY_MSG      = 4'd11,
  parameter int unsigned TIMEOUT_CYC   = 1_000_000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            interboard_rst,
  input  logic            done_and_next,
  input  logic            draw_and_next,
  input  logic [6:0]      my_card_cnt,
  input  logic            deck_empty,
  input  logic [3:0]      cur_game_state,
  input  logic            inter_ready,
  input  logic            interboard_en,
  input  logic [3:0]      interboard_msg_type,
  input  logic [5:0]      interboard_card,
  output logic            game_over,
  output logic [ID_W-1:0] winner_id,
  output logic [1:0]      end_reason,
  output logic            send_fail,
  output logic            ge_ctrl_en,
  output logic [3:0]      ge_ctrl_msg_type,
  output logic [5:0]      ge_ctrl_card,
  output logic            ge_ctrl_move_dir,
  output logic [2:0]      ge_ctrl_sel_len,
  output logic [4:0]      ge_ctrl_block_x,
  output logic [2:0]      ge_ctrl_block_y
);

  localparam int unsigned  TIMER_W      = $clog2(TIMEOUT_CYC) + 1;
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYC - 1);
  localparam logic [2:0]   NP3          = 3'(NUM_PLAYERS);
  localparam logic [5:0]   PLAYER_CARD  = 6'(PLAYER);

  localparam logic [1:0] R_LOCAL  = 2'd1;
  localparam logic [1:0] R_REMOTE = 2'd2;
  localparam logic [1:0] R_DRAW   = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  state_t               state, state_next;
  logic [2:0]           pass_cnt, pass_cnt_next;
  logic [TIMER_W-1:0]   timer, timer_next;
  logic [ID_W-1:0]      winner_q, winner_next;
  logic [1:0]           reason_q, reason_next;
  logic                 fail_q, fail_next;

  logic reset_any;
  logic my_turn;
  logic rx_win;
  logic rx_lower;
  logic local_win;
  logic pass_inc;
  logic pass_clr;
  logic pass_hit;

  assign reset_any = rst | interboard_rst;
  assign my_turn   = (cur_game_state == MY_TURN_STATE);
  assign rx_win    = interboard_en & (interboard_msg_type == WIN_MSG);
  // A remote winner only beats us when its id is strictly lower than ours.
  assign rx_lower  = (interboard_card < PLAYER_CARD);
  assign local_win = my_turn & done_and_next & (my_card_cnt == 7'd0);

  assign pass_inc = deck_empty &
                    ((my_turn & draw_and_next) |
                     (interboard_en & (interboard_msg_type == PASS_MSG)));
  assign pass_clr = done_and_next |
                    (interboard_en & (interboard_msg_type == PLAY_MSG)) |
                    ~deck_empty;
  // Draw fires on the pass that completes a full round of passes.
  assign pass_hit = pass_inc & ~pass_clr & ((pass_cnt + 3'd1) >= NP3);

  always_comb begin
    state_next    = state;
    pass_cnt_next = pass_cnt;
    timer_next    = '0;
    winner_next   = winner_q;
    reason_next   = reason_q;
    fail_next     = fail_q;
    ge_ctrl_en    = 1'b0;

    case (state)
      S_IDLE: begin
        if (pass_clr) begin
          pass_cnt_next = 3'd0;
        end else if (pass_inc && (pass_cnt < NP3)) begin
          pass_cnt_next = pass_cnt + 3'd1;
        end

        if (rx_win && (rx_lower || !local_win)) begin
          state_next  = S_FIN;
          winner_next = interboard_card[ID_W-1:0];
          reason_next = R_REMOTE;
        end else if (local_win) begin
          state_next = S_SEND;
        end else if (pass_hit) begin
          state_next  = S_FIN;
          winner_next = ID_W'(NUM_PLAYERS);
          reason_next = R_DRAW;
        end
      end

      S_SEND: begin
        if (rx_win && rx_lower) begin
          state_next  = S_FIN;
          winner_next = interboard_card[ID_W-1:0];
          reason_next = R_REMOTE;
        end else if (inter_ready) begin
          ge_ctrl_en  = ~reset_any;
          state_next  = S_FIN;
          winner_next = ID_W'(PLAYER);
          reason_next = R_LOCAL;
        end else if (timer == TIMER_LAST) begin
          state_next  = S_FIN;
          winner_next = ID_W'(PLAYER);
          reason_next = R_LOCAL;
          fail_next   = 1'b1;
        end else begin
          timer_next = timer + TIMER_W'(1);
        end
      end

      S_FIN: begin
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset_any) begin
      state    <= S_IDLE;
      pass_cnt <= 3'd0;
      timer    <= '0;
      winner_q <= '0;
      reason_q <= 2'd0;
      fail_q   <= 1'b0;
    end else begin
      state    <= state_next;
      pass_cnt <= pass_cnt_next;
      timer    <= timer_next;
      winner_q <= winner_next;
      reason_q <= reason_next;
      fail_q   <= fail_next;
    end
  end

  assign game_over        = (state == S_FIN);
  assign winner_id        = winner_q;
  assign end_reason       = reason_q;
  assign send_fail        = fail_q;
  assign ge_ctrl_msg_type = WIN_MSG;
  assign ge_ctrl_card     = PLAYER_CARD;
  assign ge_ctrl_move_dir = 1'b0;
  assign ge_ctrl_sel_len  = 3'd0;
  assign ge_ctrl_block_x  = 5'd0;
  assign ge_ctrl_block_y  = 3'd0;

endmodule

// File: tb/tb_handle_game_end.sv
// tb/tb_handle_game_end.sv - self-checking bench for handle_game_end
//
// Purpose: table-driven cycle vectors, directed ready-stall and timeout sequences,
// then random stimulus against a behavioural model of the end-of-game rules.
// Ports: none (top-level bench).

module tb_handle_game_end;

  localparam int unsigned PLAYER = 1;
  localparam int unsigned NP     = 3;
  localparam int unsigned ID_W   = 3;
  localparam int unsigned TO     = 16;
  localparam logic [3:0]  MT     = 4'd3;
  localparam logic [3:0]  WM     = 4'd9;
  localparam logic [3:0]  PM     = 4'd10;
  localparam logic [3:0]  LM     = 4'd11;

  logic            clk = 1'b0;
  logic            rst, interboard_rst, done_and_next, draw_and_next;
  logic [6:0]      my_card_cnt;
  logic            deck_empty;
  logic [3:0]      cur_game_state;
  logic            inter_ready, interboard_en;
  logic [3:0]      interboard_msg_type;
  logic [5:0]      interboard_card;
  logic            game_over;
  logic [ID_W-1:0] winner_id;
  logic [1:0]      end_reason;
  logic            send_fail, ge_ctrl_en;
  logic [3:0]      ge_ctrl_msg_type;
  logic [5:0]      ge_ctrl_card;
  logic            ge_ctrl_move_dir;
  logic [2:0]      ge_ctrl_sel_len;
  logic [4:0]      ge_ctrl_block_x;
  logic [2:0]      ge_ctrl_block_y;

  always #5 clk = ~clk;

  handle_game_end #(
    .PLAYER(PLAYER), .NUM_PLAYERS(NP), .ID_W(ID_W), .MY_TURN_STATE(MT),
    .WIN_MSG(WM), .PASS_MSG(PM), .PLAY_MSG(LM), .TIMEOUT_CYC(TO)
  ) dut (
    .clk(clk), .rst(rst), .interboard_rst(interboard_rst),
    .done_and_next(done_and_next), .draw_and_next(draw_and_next),
    .my_card_cnt(my_card_cnt), .deck_empty(deck_empty),
    .cur_game_state(cur_game_state), .inter_ready(inter_ready),
    .interboard_en(interboard_en), .interboard_msg_type(interboard_msg_type),
    .interboard_card(interboard_card), .game_over(game_over),
    .winner_id(winner_id), .end_reason(end_reason), .send_fail(send_fail),
    .ge_ctrl_en(ge_ctrl_en), .ge_ctrl_msg_type(ge_ctrl_msg_type),
    .ge_ctrl_card(ge_ctrl_card), .ge_ctrl_move_dir(ge_ctrl_move_dir),
    .ge_ctrl_sel_len(ge_ctrl_sel_len), .ge_ctrl_block_x(ge_ctrl_block_x),
    .ge_ctrl_block_y(ge_ctrl_block_y)
  );

  // {game_over, winner_id, end_reason, send_fail, ge_ctrl_en}
  logic [7:0] obs;
  assign obs = {game_over, winner_id, end_reason, send_fail, ge_ctrl_en};

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic       r, ir, d, dr;
    logic [6:0] cnt;
    logic       de;
    logic [3:0] gs;
    logic       rdy, ien;
    logic [3:0] typ;
    logic [5:0] card;
    logic [7:0] ex;
  } vec_t;

  vec_t tab[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] e(input bit over, input int win, input int rsn,
                                   input bit fail, input bit en);
    return {over, 3'(win), 2'(rsn), fail, en};
  endfunction

  function automatic vec_t mk(input bit r, input bit ir, input bit d, input bit dr,
                              input int cnt, input bit de, input int gs, input bit rdy,
                              input bit ien, input int typ, input int card,
                              input logic [7:0] ex);
    vec_t v;
    v.r = r; v.ir = ir; v.d = d; v.dr = dr; v.cnt = 7'(cnt); v.de = de;
    v.gs = 4'(gs); v.rdy = rdy; v.ien = ien; v.typ = 4'(typ); v.card = 6'(card);
    v.ex = ex;
    return v;
  endfunction

  task automatic apply(input vec_t v);
    rst = v.r; interboard_rst = v.ir; done_and_next = v.d; draw_and_next = v.dr;
    my_card_cnt = v.cnt; deck_empty = v.de; cur_game_state = v.gs;
    inter_ready = v.rdy; interboard_en = v.ien; interboard_msg_type = v.typ;
    interboard_card = v.card;
  endtask

  task automatic next_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    apply(mk(1, 0, 0, 0, 5, 0, 0, 0, 0, 0, 0, 8'h00));
    next_edge();
  endtask

  // behavioural model state
  bit m_over, m_send, m_fail;
  int m_winner, m_reason, m_wait, m_passes;

  task automatic model_clear();
    m_over = 0; m_send = 0; m_fail = 0;
    m_winner = 0; m_reason = 0; m_wait = 0; m_passes = 0;
  endtask

  initial begin
    int strobes, first_strobe, n;
    bit hit;
    vec_t v;

    do_reset();
    do_reset();

    // reset state
    tab.push_back(mk(1,0, 0,0,5,0,0,  0, 0,0,0, e(0,0,0,0,0)));
    // local win, ready high: strobe at t+1, game_over at t+2
    tab.push_back(mk(0,0, 1,0,0,0,MT, 1, 0,0,0, e(0,0,0,0,0)));
    tab.push_back(mk(0,0, 0,0,5,0,0,  1, 0,0,0, e(0,0,0,0,1)));
    tab.push_back(mk(0,0, 0,0,5,0,0,  0, 0,0,0, e(1,1,1,0,0)));
    tab.push_back(mk(0,0, 1,0,0,0,MT, 1, 1,WM,0, e(1,1,1,0,0)));
    // interboard_rst while in FIN
    tab.push_back(mk(0,1, 0,0,5,0,0,  0, 0,0,0, e(1,1,1,0,0)));
    tab.push_back(mk(0,0, 0,0,5,0,0,  1, 0,0,0, e(0,0,0,0,0)));
    // remote win from a higher id
    tab.push_back(mk(0,0, 0,0,5,0,0,  0, 1,WM,2, e(0,0,0,0,0)));
    tab.push_back(mk(0,0, 0,0,5,0,0,  1, 0,0,0, e(1,2,2,0,0)));
    tab.push_back(mk(1,0, 0,0,5,0,0,  0, 0,0,0, e(1,2,2,0,0)));
    // same cycle local + remote, remote id lower -> remote win, no strobe
    tab.push_back(mk(0,0, 1,0,0,0,MT, 1, 1,WM,0, e(0,0,0,0,0)));
    tab.push_back(mk(0,0, 0,0,5,0,0,  1, 0,0,0, e(1,0,2,0,0)));
    tab.push_back(mk(1,0, 0,0,5,0,0,  0, 0,0,0, e(1,0,2,0,0)));
    // same cycle, remote id higher -> SEND; higher remote ignored in SEND; link reset in SEND
    tab.push_back(mk(0,0, 1,0,0,0,MT, 0, 1,WM,2, e(0,0,0,0,0)));
    tab.push_back(mk(0,0, 0,0,5,0,0,  0, 0,0,0, e(0,0,0,0,0)));
    tab.push_back(mk(0,0, 0,0,5,0,0,  0, 1,WM,2, e(0,0,0,0,0)));
    tab.push_back(mk(0,1, 0,0,5,0,0,  1, 0,0,0, e(0,0,0,0,0)));
    tab.push_back(mk(0,0, 0,0,5,0,0,  1, 0,0,0, e(0,0,0,0,0)));
    // draw: passes local/remote, PLAY clears, then local/remote/remote
    tab.push_back(mk(0,0, 0,1,5,1,MT, 0, 0,0,0, e(0,0,0,0,0)));
    tab.push_back(mk(0,0, 0,0,5,1,0,  0, 1,PM,0, e(0,0,0,0,0)));
    tab.push_back(mk(0,0, 0,0,5,1,0,  0, 1,LM,0, e(0,0,0,0,0)));
    tab.push_back(mk(0,0, 0,1,5,1,MT, 0, 0,0,0, e(0,0,0,0,0)));
    tab.push_back(mk(0,0, 0,0,5,1,0,  0, 1,PM,0, e(0,0,0,0,0)));
    tab.push_back(mk(0,0, 0,0,5,1,0,  0, 1,PM,0, e(0,0,0,0,0)));
    tab.push_back(mk(0,0, 0,0,5,1,0,  0, 0,0,0, e(1,3,3,0,0)));
    tab.push_back(mk(1,0, 0,0,5,1,0,  0, 0,0,0, e(1,3,3,0,0)));
    // deck_empty low clears the count
    tab.push_back(mk(0,0, 0,0,5,1,0,  0, 1,PM,0, e(0,0,0,0,0)));
    tab.push_back(mk(0,0, 0,0,5,1,0,  0, 1,PM,0, e(0,0,0,0,0)));
    tab.push_back(mk(0,0, 0,0,5,0,0,  0, 0,0,0, e(0,0,0,0,0)));
    tab.push_back(mk(0,0, 0,0,5,1,0,  0, 1,PM,0, e(0,0,0,0,0)));
    tab.push_back(mk(0,0, 0,0,5,1,0,  0, 1,PM,0, e(0,0,0,0,0)));
    tab.push_back(mk(0,0, 0,0,5,1,0,  0, 0,0,0, e(0,0,0,0,0)));
    tab.push_back(mk(0,0, 0,0,5,1,0,  0, 1,PM,0, e(0,0,0,0,0)));
    tab.push_back(mk(0,0, 0,0,5,1,0,  0, 0,0,0, e(1,3,3,0,0)));
    tab.push_back(mk(1,0, 0,0,5,1,0,  0, 0,0,0, e(1,3,3,0,0)));
    // win beats a completing pass in the same cycle
    tab.push_back(mk(0,0, 0,0,5,1,0,  0, 1,PM,0, e(0,0,0,0,0)));
    tab.push_back(mk(0,0, 0,0,5,1,0,  0, 1,PM,0, e(0,0,0,0,0)));
    tab.push_back(mk(0,0, 0,1,5,1,MT, 0, 1,WM,2, e(0,0,0,0,0)));
    tab.push_back(mk(0,0, 0,0,5,1,0,  0, 0,0,0, e(1,2,2,0,0)));
    tab.push_back(mk(1,0, 0,0,5,1,0,  0, 0,0,0, e(1,2,2,0,0)));
    // no local win with cards left or off-turn
    tab.push_back(mk(0,0, 1,0,3,0,MT, 1, 0,0,0, e(0,0,0,0,0)));
    tab.push_back(mk(0,0, 0,0,5,0,0,  1, 0,0,0, e(0,0,0,0,0)));
    tab.push_back(mk(0,0, 1,0,0,0,0,  1, 0,0,0, e(0,0,0,0,0)));
    tab.push_back(mk(0,0, 0,0,5,0,0,  1, 0,0,0, e(0,0,0,0,0)));

    for (int i = 0; i < tab.size(); i++) begin
      apply(tab[i]);
      @(negedge clk);
      check($sformatf("vec%0d", i), 64'(obs), 64'(tab[i].ex));
      next_edge();
    end

    check("ctrl_const",
          64'({ge_ctrl_msg_type, ge_ctrl_card, ge_ctrl_move_dir, ge_ctrl_sel_len,
               ge_ctrl_block_x, ge_ctrl_block_y}),
          64'({WM, 6'(PLAYER), 1'b0, 3'd0, 5'd0, 3'd0}));

    // ready low for 5 cycles: exactly one strobe on the first ready cycle
    do_reset();
    apply(mk(0,0, 1,0,0,0,MT, 0, 0,0,0, 8'h00));
    next_edge();
    strobes = 0;
    first_strobe = -1;
    for (int i = 0; i < 9; i++) begin
      apply(mk(0,0, 0,0,5,0,0, (i >= 5), 0,0,0, 8'h00));
      @(negedge clk);
      if (ge_ctrl_en) begin
        strobes++;
        if (first_strobe < 0) first_strobe = i;
      end
      next_edge();
    end
    check("stall_strobes", 64'(strobes), 64'd1);
    check("stall_first", 64'(first_strobe), 64'd5);
    check("stall_end", 64'({game_over, end_reason, send_fail}), 64'({1'b1, 2'd1, 1'b0}));

    // ready stuck low: timeout after TO SEND cycles
    do_reset();
    apply(mk(0,0, 1,0,0,0,MT, 0, 0,0,0, 8'h00));
    next_edge();
    strobes = 0;
    n = 0;
    hit = 0;
    while (!hit && n < 40) begin
      apply(mk(0,0, 0,0,5,0,0, 0, 0,0,0, 8'h00));
      @(negedge clk);
      if (game_over) begin
        hit = 1;
      end else begin
        if (ge_ctrl_en) strobes++;
        n++;
      end
      next_edge();
    end
    check("timeout_reached", 64'(hit), 64'd1);
    check("timeout_cycles", 64'(n), 64'(TO));
    check("timeout_strobes", 64'(strobes), 64'd0);
    check("timeout_end", 64'({winner_id, end_reason, send_fail}), 64'({3'(PLAYER), 2'd1, 1'b1}));

    // random stimulus against the rule model
    do_reset();
    model_clear();
    for (int c = 0; c < 3000; c++) begin
      bit rsn, exp_en, my_t, rx_w, rx_low, lwin;
      logic [7:0] exp_o;
      v.r   = ($urandom_range(0, 39) == 0);
      v.ir  = ($urandom_range(0, 59) == 0);
      v.d   = ($urandom_range(0, 5) == 0);
      v.dr  = ($urandom_range(0, 3) == 0);
      v.cnt = $urandom_range(0, 1) ? 7'd0 : 7'($urandom_range(1, 20));
      v.de  = ($urandom_range(0, 3) != 0);
      v.gs  = $urandom_range(0, 1) ? MT : 4'($urandom_range(0, 15));
      v.rdy = ($urandom_range(0, 2) == 0);
      v.ien = ($urandom_range(0, 2) == 0);
      case ($urandom_range(0, 4))
        0:       v.typ = WM;
        1, 2:    v.typ = PM;
        3:       v.typ = LM;
        default: v.typ = 4'($urandom_range(0, 15));
      endcase
      v.card = ($urandom_range(0, 7) == 0) ? 6'($urandom_range(0, 63))
                                           : 6'($urandom_range(0, 3));
      v.ex = 8'h00;
      apply(v);

      rsn    = v.r || v.ir;
      my_t   = (v.gs == MT);
      rx_w   = v.ien && (v.typ == WM);
      rx_low = (int'(v.card) < int'(PLAYER));
      lwin   = my_t && v.d && (v.cnt == 0);
      exp_en = m_send && !rsn && !(rx_w && rx_low) && v.rdy;
      exp_o  = {m_over, 3'(m_winner), 2'(m_reason), m_fail, exp_en};

      @(negedge clk);
      check($sformatf("rand%0d", c), 64'(obs), 64'(exp_o));

      if (rsn) begin
        model_clear();
      end else if (m_over) begin
      end else if (m_send) begin
        if (rx_w && rx_low) begin
          m_over = 1; m_send = 0; m_winner = int'(v.card) % 8; m_reason = 2;
        end else if (v.rdy) begin
          m_over = 1; m_send = 0; m_winner = PLAYER; m_reason = 1;
        end else if (m_wait == TO - 1) begin
          m_over = 1; m_send = 0; m_winner = PLAYER; m_reason = 1; m_fail = 1;
        end else begin
          m_wait++;
        end
      end else begin
        if (rx_w && (rx_low || !lwin)) begin
          m_over = 1; m_winner = int'(v.card) % 8; m_reason = 2;
        end else if (lwin) begin
          m_send = 1; m_wait = 0;
        end else begin
          if (v.d || (v.ien && v.typ == LM) || !v.de) begin
            m_passes = 0;
          end else if (v.de && ((my_t && v.dr) || (v.ien && v.typ == PM))) begin
            m_passes = (m_passes + 1 > NP) ? NP : m_passes + 1;
          end
          if (m_passes == NP) begin
            m_over = 1; m_winner = NP; m_reason = 3;
          end
        end
      end
      next_edge();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
